// File: rtl/linescanner_pkg.sv
// Shared types and constants for the line-scanner pattern source.
// Pattern modes, FSM encoding and the 16-bit LFSR definition.
package linescanner_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_CONST   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] r);
        return {^(r & LFSR_TAPS), r[15:1]};
    endfunction

endpackage

// File: rtl/linescanner_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
// Holds its value whenever step is low.
module linescanner_lfsr16
    import linescanner_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (seed_load) begin
            value <= LFSR_SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/linescanner_pattern_generator.sv
// Line-scanner source model: framed scan lines with blanking and
// four test patterns on a valid/ready pixel stream.
module linescanner_pattern_generator
    import linescanner_pkg::*;
#(
    parameter int PIXEL_WIDTH      = 8,
    parameter int LINE_LENGTH      = 1024,
    parameter int LINE_GAP         = 4,
    parameter int BAR_WIDTH        = 8,
    parameter int LINE_COUNT_WIDTH = 16
) (
    input  logic                        main_clock_source,
    input  logic                        n_reset,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [PIXEL_WIDTH-1:0]      constant_value,
    input  logic                        pixel_ready,
    output logic [PIXEL_WIDTH-1:0]      pixel_data,
    output logic                        pixel_captured,
    output logic                        line_start,
    output logic                        line_end,
    output logic [LINE_COUNT_WIDTH-1:0] line_count
);

    localparam int IDX_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int BAR_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
    localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINE_LENGTH - 1);
    localparam logic [BAR_W-1:0] BAR_LAST = BAR_W'(BAR_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic SINGLE_PIXEL = (LINE_LENGTH == 1);
    localparam logic NO_GAP       = (LINE_GAP == 0);

    state_t                      state;
    mode_t                       mode_q;
    logic [PIXEL_WIDTH-1:0]      const_q;
    logic [IDX_W-1:0]            idx;
    logic [BAR_W-1:0]            bar_cnt;
    logic                        bar_par;
    logic                        line_par;
    logic [GAP_W-1:0]            blank_cnt;

    logic [15:0]                 lfsr_value;
    logic [15:0]                 lfsr_after;
    logic                        seed_load;
    logic                        transfer;
    logic                        abort;
    logic                        line_done;
    logic                        start_line;
    logic                        to_blank;
    logic                        advance;
    logic [LINE_COUNT_WIDTH-1:0] cnt_inc;
    logic                        start_par;
    logic [PIXEL_WIDTH-1:0]      start_pix;
    logic [IDX_W-1:0]            next_idx;
    logic [BAR_W-1:0]            next_bar_cnt;
    logic                        next_bar_par;
    logic [PIXEL_WIDTH-1:0]      next_pix;

    function automatic logic [PIXEL_WIDTH-1:0] pattern(
        input mode_t                  m,
        input logic [IDX_W-1:0]       i,
        input logic                   bp,
        input logic                   lp,
        input logic [PIXEL_WIDTH-1:0] cv,
        input logic [15:0]            r
    );
        logic [PIXEL_WIDTH-1:0] p;
        p = '0;
        unique case (m)
            MODE_RAMP:    p = PIXEL_WIDTH'(i);
            MODE_CONST:   p = cv;
            MODE_CHECKER: p = (bp ^ lp) ? '1 : '0;
            MODE_LFSR:    p = PIXEL_WIDTH'(r);
        endcase
        return p;
    endfunction

    linescanner_lfsr16 u_lfsr (
        .clk       (main_clock_source),
        .rst_n     (n_reset),
        .seed_load (seed_load),
        .step      (transfer),
        .value     (lfsr_value)
    );

    always_comb begin
        abort     = (state != ST_IDLE) && !enable;
        seed_load = (state == ST_IDLE) && enable;
        transfer  = (state == ST_ACTIVE) && enable
                  && pixel_captured && pixel_ready;
        line_done = transfer && (idx == IDX_LAST);
        to_blank  = line_done && !NO_GAP;
        advance   = transfer && !line_done;
        start_line = seed_load
                   || (line_done && NO_GAP)
                   || ((state == ST_BLANK) && enable
                       && (blank_cnt == GAP_LAST));

        // registered pixel must match the LFSR value after this edge
        if (seed_load) begin
            lfsr_after = LFSR_SEED;
        end else if (transfer) begin
            lfsr_after = lfsr_next(lfsr_value);
        end else begin
            lfsr_after = lfsr_value;
        end

        cnt_inc   = line_count + LINE_COUNT_WIDTH'(1);
        start_par = (state == ST_ACTIVE) ? cnt_inc[0] : line_count[0];
        start_pix = pattern(mode_t'(mode), '0, 1'b0, start_par,
                            constant_value, lfsr_after);

        next_idx     = idx + IDX_W'(1);
        next_bar_cnt = (bar_cnt == BAR_LAST) ? '0 : bar_cnt + BAR_W'(1);
        next_bar_par = (bar_cnt == BAR_LAST) ? ~bar_par : bar_par;
        next_pix     = pattern(mode_q, next_idx, next_bar_par, line_par,
                               const_q, lfsr_after);
    end

    always_ff @(posedge main_clock_source or negedge n_reset) begin
        if (!n_reset) begin
            state          <= ST_IDLE;
            mode_q         <= MODE_RAMP;
            const_q        <= '0;
            idx            <= '0;
            bar_cnt        <= '0;
            bar_par        <= 1'b0;
            line_par       <= 1'b0;
            blank_cnt      <= '0;
            line_count     <= '0;
            pixel_data     <= '0;
            pixel_captured <= 1'b0;
            line_start     <= 1'b0;
            line_end       <= 1'b0;
        end else if (abort) begin
            state          <= ST_IDLE;
            idx            <= '0;
            bar_cnt        <= '0;
            bar_par        <= 1'b0;
            line_par       <= 1'b0;
            blank_cnt      <= '0;
            line_count     <= '0;
            pixel_data     <= '0;
            pixel_captured <= 1'b0;
            line_start     <= 1'b0;
            line_end       <= 1'b0;
        end else begin
            if (line_done) begin
                line_count <= cnt_inc;
            end
            if (start_line) begin
                state          <= ST_ACTIVE;
                mode_q         <= mode_t'(mode);
                const_q        <= constant_value;
                idx            <= '0;
                bar_cnt        <= '0;
                bar_par        <= 1'b0;
                line_par       <= start_par;
                pixel_data     <= start_pix;
                pixel_captured <= 1'b1;
                line_start     <= 1'b1;
                line_end       <= SINGLE_PIXEL;
                if (seed_load) begin
                    line_count <= '0;
                end
            end else if (to_blank) begin
                state          <= ST_BLANK;
                blank_cnt      <= '0;
                pixel_data     <= '0;
                pixel_captured <= 1'b0;
                line_start     <= 1'b0;
                line_end       <= 1'b0;
            end else if (advance) begin
                idx        <= next_idx;
                bar_cnt    <= next_bar_cnt;
                bar_par    <= next_bar_par;
                pixel_data <= next_pix;
                line_start <= 1'b0;
                line_end   <= (next_idx == IDX_LAST);
            end else if (state == ST_BLANK) begin
                blank_cnt <= blank_cnt + GAP_W'(1);
            end
        end
    end

endmodule

// File: doc/linescanner_pattern_generator.md
# linescanner_pattern_generator

Parametrised line-scanner source model. It produces complete scan lines of configurable length and pixel width, with inter-line blanking and four selectable test patterns. Output is a valid/ready pixel stream with line framing strobes. It replaces the fixed 8-bit ramp mimic at the head of the image capture path, so downstream buffering and DMA logic can be exercised with realistic line structure and backpressure.

## Interface
- `PIXEL_WIDTH`, default 8: pixel bits; legal range 1..16.
- `LINE_LENGTH`, default 1024: pixels per line; must be ≥1.
- `LINE_GAP`, default 4: blanking cycles between lines; 0 means back-to-back lines.
- `BAR_WIDTH`, default 8: pixels per bar in checker mode; must be ≥1.
- `LINE_COUNT_WIDTH`, default 16: width of the completed-line counter.
- `main_clock_source`, input, 1: sole clock; all logic on its rising edge.
- `n_reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: run request; level-sensitive.
- `mode`, input, 2: pattern select; 0 = ramp, 1 = constant, 2 = checker, 3 = LFSR.
- `constant_value`, input, PIXEL_WIDTH: pixel value used in constant mode.
- `pixel_ready`, input, 1: downstream accepts the current pixel.
- `pixel_data`, output, PIXEL_WIDTH: current pixel.
- `pixel_captured`, output, 1: pixel valid.
- `line_start`, output, 1: current pixel is index 0 of its line.
- `line_end`, output, 1: current pixel is index LINE_LENGTH-1.
- `line_count`, output, LINE_COUNT_WIDTH: lines completed since enable rose; wraps modulo 2^LINE_COUNT_WIDTH.

## Operation
- **FSM states:** IDLE, ACTIVE, BLANK.
- **IDLE:**
  - All outputs are 0.
  - `enable`=1 sampled at an edge → ACTIVE. The same edge registers pixel 0 with `pixel_captured`=1 and `line_start`=1.
  - At that edge: latch `mode` and `constant_value`, clear `line_count`, seed the LFSR to 16'hACE1.
- **ACTIVE:**
  - A transfer occurs at an edge where `pixel_captured`=1 and `pixel_ready`=1.
  - On transfer of index i < LINE_LENGTH-1: present index i+1.
  - On transfer of index LINE_LENGTH-1: increment `line_count`, then:
    - LINE_GAP > 0 → go to BLANK with valid low;
    - LINE_GAP = 0 → present index 0 of the next line at the same edge.
  - With no transfer, `pixel_data`, `pixel_captured`, `line_start` and `line_end` hold unchanged.
- **BLANK:**
  - Counts exactly LINE_GAP cycles with `pixel_captured`=0.
  - The edge that ends the count presents index 0 of the next line.
- **Line-start sampling:** `mode` and `constant_value` are re-latched at every line start. Changes mid-line have no effect until the next line.
- **`enable`=0 sampled in ACTIVE or BLANK:**
  - Abort at that edge: go to IDLE with all outputs 0 and counters cleared.
  - A pending unaccepted pixel is discarded.
  - `line_count` reads 0.
- **Patterns** (i = pixel index within the line; L = `line_count` value at line start):
  - Ramp: i mod 2^PIXEL_WIDTH. Restarts at 0 each line and wraps from all-ones to 0 within a line.
  - Constant: the latched `constant_value`.
  - Checker: all-ones when bit 0 of (i / BAR_WIDTH) XOR bit 0 of L is 1, otherwise 0. Line 0 therefore begins dark.
  - LFSR:
    - 16-bit Fibonacci register, polynomial x^16+x^14+x^13+x^11+1.
    - Steps once per transferred pixel only; it does not step during stalls or blanking.
    - Output = low PIXEL_WIDTH bits of the register.
    - The sequence continues across lines and re-seeds only on IDLE→ACTIVE.
- **Pixel index counter:** $clog2(LINE_LENGTH) bits, minimum 1 bit. Bar counter: $clog2(BAR_WIDTH) bits.

## Timing
- **Reset:** all outputs are 0, state IDLE, LFSR = 16'hACE1. Reset takes effect immediately on `n_reset` low, regardless of clock, including mid-line.
- **Start latency:** first valid pixel appears 1 cycle after `enable` is sampled high.
- **Throughput:** 1 pixel per cycle with `pixel_ready` tied high.
- **Line period** (`pixel_ready` high): LINE_LENGTH + LINE_GAP cycles.
- **LINE_LENGTH = 1:** `line_start` and `line_end` are both high on the same pixel.
- **Abort latency:** outputs read 0 one edge after `enable` is sampled low.
- **Valid rule:** `pixel_captured` never deasserts without a transfer, except on abort or reset.

## Structure
- **Package `linescanner_pkg`:**
  - mode constants `MODE_RAMP`, `MODE_CONST`, `MODE_CHECKER`, `MODE_LFSR`;
  - FSM state encoding;
  - `LFSR_SEED` = 16'hACE1 and the tap mask.
- **Sub-module `linescanner_lfsr16`:** ports are clock, reset, `seed_load`, `step` and `value[15:0]`. The top level handles the FSM, counters and pattern mux.

## Test plan
- Defaults, `mode`=0, `pixel_ready`=1, `enable` held → pixels 0..255 repeated 4 times, `line_end` at pixel 1023, 4 blank cycles, `line_count`=1, next line restarts at 0.
- LINE_LENGTH=16, `mode`=2, BAR_WIDTH=4 → line 0 is 0×4, FF×4, 0×4, FF×4; line 1 is inverted.
- `pixel_ready` held low for 3 cycles on pixel 5 → `pixel_data`=5 and valid held for 3 cycles, then pixel 6; LFSR mode likewise does not advance.
- `mode` changed 1→3 mid-line with `constant_value`=8'h5A → remainder of the line stays 8'h5A; next line is LFSR starting with the low byte of the current register value.
- `enable` dropped at pixel 10 → next edge outputs 0, `line_count`=0; re-enable restarts at pixel 0 and LFSR re-seeds (first LFSR pixel 8'hE1).
- `n_reset` pulsed asynchronously mid-line → outputs 0 before the next edge; LINE_GAP=0 case shows `line_end` followed immediately by `line_start`.
